led_pulse_stretcher: RTL and testbench



---
 rtl/led_driver_pkg.sv | 21 ++
 rtl/ms_tick_gen.sv | 32 +++
 rtl/led_pulse_stretcher.sv | 135 +++++++++++++
 tb/tb_led_pulse_stretcher.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_driver_pkg.sv
// led_driver_pkg: shared types and elaboration-time helpers for the LED pulse
// stretcher and its millisecond tick prescaler.
//   state_t       per-channel hold state (IDLE, HOLD)
//   tick_cycles() clock cycles per 1 ms tick
//   cnt_width()   bits needed for a counter holding 0..max_val (minimum 1)
package led_driver_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic int unsigned tick_cycles(input int unsigned clk_hz);
    return clk_hz / 1000;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: free-running 1 ms prescaler. Counts 0..TICK_CYCLES-1 and wraps.
//   clk   in   system clock
//   reset in   synchronous, active-high; clears the prescaler to 0
//   tick  out  combinational, high in the last cycle of each 1 ms period
//              (permanently high when TICK_CYCLES == 1)
module ms_tick_gen
  import led_driver_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned TC = tick_cycles(CLK_HZ);
  localparam int unsigned PW = cnt_width(TC - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == PW'(TC - 1));

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_pulse_stretcher.sv
// led_pulse_stretcher: turns single-cycle event pulses into fixed-length,
// human-visible LED pulses. One retriggerable hold channel per LED, all sharing
// one 1 ms tick.
//   clk      in   system clock
//   reset    in   synchronous, active-high; aborts every pulse
//   trigger  in   [CHANNELS] start / retrigger (reloads HOLD_MS)
//   cancel   in   [CHANNELS] immediate stop, beats a coincident trigger
//   led      out  [CHANNELS] registered LED drive
//   busy     out  registered, high while any channel is in HOLD
// Optional build macro LED_BLINK_EN: LEDs blink with a BLINK_MS half-period
// while holding instead of staying steadily on (busy ignores the blink phase).
module led_pulse_stretcher
  import led_driver_pkg::*;
#(
  parameter int unsigned CHANNELS = 18,
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned HOLD_MS  = 250,
  parameter int unsigned BLINK_MS = 50
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] trigger,
  input  logic [CHANNELS-1:0] cancel,
  output logic [CHANNELS-1:0] led,
  output logic                busy
);

  localparam int unsigned RW = cnt_width(HOLD_MS);

  logic                tick;
  logic [CHANNELS-1:0] hold_d;
  logic [CHANNELS-1:0] led_d;
  logic [CHANNELS-1:0] led_q;
  logic                busy_q;

  ms_tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_t        state_q, state_d;
    logic [RW-1:0] rem_q, rem_d;

    always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      if (cancel[g]) begin
        state_d = IDLE;
        rem_d   = '0;
      end else if (trigger[g]) begin
        // Retrigger wins over a coincident tick: full reload, no decrement.
        state_d = HOLD;
        rem_d   = RW'(HOLD_MS);
      end else if (state_q == HOLD && tick) begin
        if (rem_q == RW'(1)) begin
          state_d = IDLE;
          rem_d   = '0;
        end else begin
          rem_d = rem_q - RW'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= IDLE;
        rem_q   <= '0;
      end else begin
        state_q <= state_d;
        rem_q   <= rem_d;
      end
    end

    // Outputs are registered from next state so the LED follows the
    // trigger by exactly one cycle.
    assign hold_d[g] = (state_d == HOLD);

`ifdef LED_BLINK_EN
    localparam int unsigned BW = cnt_width(BLINK_MS);

    logic [BW-1:0] blink_q, blink_d;
    logic          phase_q, phase_d;

    always_comb begin
      blink_d = blink_q;
      phase_d = phase_q;
      if (!cancel[g]) begin
        if (trigger[g]) begin
          phase_d = 1'b1;
          blink_d = BW'(BLINK_MS);
        end else if (state_q == HOLD && tick) begin
          if (blink_q == BW'(1)) begin
            phase_d = ~phase_q;
            blink_d = BW'(BLINK_MS);
          end else begin
            blink_d = blink_q - BW'(1);
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        blink_q <= BW'(BLINK_MS);
        phase_q <= 1'b1;
      end else begin
        blink_q <= blink_d;
        phase_q <= phase_d;
      end
    end

    assign led_d[g] = hold_d[g] & phase_d;
`else
    assign led_d[g] = hold_d[g];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      led_q  <= led_d;
      busy_q <= |hold_d;
    end
  end

  assign led  = led_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Self-checking bench for led_pulse_stretcher (CHANNELS=4, CLK_HZ=4000,
// HOLD_MS=3, BLINK_MS=1). Reference model tracks, per channel, whether a pulse
// is active and how many ms ticks have elapsed since its last (re)trigger.
module tb_led_pulse_stretcher;

  localparam int CH     = 4;
  localparam int CLK_HZ = 4000;
  localparam int TC     = CLK_HZ / 1000;
  localparam int HOLD   = 3;
  localparam int BLINK  = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CH-1:0] trigger = '0;
  logic [CH-1:0] cancel = '0;
  logic [CH-1:0] led;
  logic          busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  led_pulse_stretcher #(
    .CHANNELS(CH),
    .CLK_HZ  (CLK_HZ),
    .HOLD_MS (HOLD),
    .BLINK_MS(BLINK)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .trigger(trigger),
    .cancel (cancel),
    .led    (led),
    .busy   (busy)
  );

  // ---------------- reference model ----------------
  bit m_act[CH];
  int m_k[CH];      // ticks elapsed since last trigger
  int m_cyc;        // cycles since reset released
  bit m_valid = 1'b0;
  bit m_tick;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CH; i++) begin
        m_act[i] = 1'b0;
        m_k[i]   = 0;
      end
      m_cyc   = 0;
      m_valid = 1'b1;
    end else begin
      m_tick = ((m_cyc % TC) == TC - 1);
      for (int i = 0; i < CH; i++) begin
        if (cancel[i]) begin
          m_act[i] = 1'b0;
        end else if (trigger[i]) begin
          m_act[i] = 1'b1;
          m_k[i]   = 0;
        end else if (m_act[i] && m_tick) begin
          m_k[i] = m_k[i] + 1;
          if (m_k[i] >= HOLD) m_act[i] = 1'b0;
        end
      end
      m_cyc = m_cyc + 1;
    end
  end

  function automatic logic [CH-1:0] exp_led();
    logic [CH-1:0] r;
    r = '0;
    for (int i = 0; i < CH; i++) begin
`ifdef LED_BLINK_EN
      r[i] = m_act[i] && (((m_k[i] / BLINK) % 2) == 0);
`else
      r[i] = m_act[i];
`endif
    end
    return r;
  endfunction

  function automatic logic exp_busy();
    logic b;
    b = 1'b0;
    for (int i = 0; i < CH; i++) b = b | m_act[i];
    return b;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      tests++;
      if (led !== exp_led() || busy !== exp_busy()) begin
        fails++;
        $display("FAIL model t=%0t led=%b busy=%b expected led=%b busy=%b",
                 $time, led, busy, exp_led(), exp_busy());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic [CH-1:0] tr, input logic [CH-1:0] cn);
    trigger = tr;
    cancel  = cn;
    @(negedge clk);
    trigger = '0;
    cancel  = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0);
  endtask

  // Leaves the bench at the negedge of cycle 0.
  task automatic do_reset();
    reset   = 1'b1;
    trigger = '0;
    cancel  = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_lit(input string name, input logic [CH-1:0] el, input logic eb);
    tests++;
    if (led !== el || busy !== eb) begin
      fails++;
      $display("FAIL %s led=%b busy=%b expected led=%b busy=%b", name, led, busy, el, eb);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

  initial begin
    // 1. basic hold
    do_reset();
    check_lit("s1_reset", 4'b0000, 1'b0);
    step(4'b0001, '0);                       // cycle 0 -> now cycle 1
    check_lit("s1_c1", 4'b0001, 1'b1);
    idle(3);                                 // cycle 4
`ifdef LED_BLINK_EN
    check_lit("s1_c4_blink", 4'b0000, 1'b1);
`else
    check_lit("s1_c4", 4'b0001, 1'b1);
`endif
    idle(7);                                 // cycle 11
    check_lit("s1_c11", 4'b0001, 1'b1);
    idle(1);                                 // cycle 12
    check_lit("s1_c12", 4'b0000, 1'b0);

    // 2. retrigger on a tick cycle
    do_reset();
    step(4'b0001, '0);                       // cycle 1
    idle(6);                                 // cycle 7
    step(4'b0001, '0);                       // cycle 8
    check_lit("s2_c8", 4'b0001, 1'b1);
    idle(11);                                // cycle 19
    check_lit("s2_c19", 4'b0001, 1'b1);
    idle(1);                                 // cycle 20
    check_lit("s2_c20", 4'b0000, 1'b0);

    // 3. cancel beats coincident trigger
    do_reset();
    step(4'b0010, '0);                       // cycle 1
    idle(4);                                 // cycle 5
    step(4'b0010, 4'b0010);                  // cycle 6
    check_lit("s3_c6", 4'b0000, 1'b0);
    idle(6);                                 // cycle 12
    check_lit("s3_c12", 4'b0000, 1'b0);

    // 4. independent channels
    do_reset();
    step(4'b0100, '0);                       // cycle 1
    idle(3);                                 // cycle 4
    step(4'b1000, '0);                       // cycle 5
`ifdef LED_BLINK_EN
    check_lit("s4_c5_blink", 4'b1000, 1'b1);
`else
    check_lit("s4_c5", 4'b1100, 1'b1);
`endif
    idle(7);                                 // cycle 12
    check_lit("s4_c12", 4'b1000, 1'b1);
    idle(3);                                 // cycle 15
    check_lit("s4_c15", 4'b1000, 1'b1);
    idle(1);                                 // cycle 16
    check_lit("s4_c16", 4'b0000, 1'b0);

    // 5. reset mid-hold, trigger held through reset
    do_reset();
    step(4'b1111, '0);                       // cycle 1
    check_lit("s5_c1", 4'b1111, 1'b1);
    idle(4);                                 // cycle 5
    reset   = 1'b1;
    trigger = 4'b1111;
    @(negedge clk);                          // cycle 6
    check_lit("s5_c6", 4'b0000, 1'b0);
    @(negedge clk);
    check_lit("s5_in_reset", 4'b0000, 1'b0);
    reset   = 1'b0;
    trigger = '0;
    @(negedge clk);
    check_lit("s5_after", 4'b0000, 1'b0);
    idle(2);
    check_lit("s5_after2", 4'b0000, 1'b0);

    // random traffic against the model
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      logic [CH-1:0] tr, cn;
      tr = '0;
      cn = '0;
      for (int i = 0; i < CH; i++) begin
        tr[i] = ($urandom_range(0, 15) == 0);
        cn[i] = ($urandom_range(0, 39) == 0);
      end
      reset = ($urandom_range(0, 499) == 0);
      step(tr, cn);
    end
    reset = 1'b0;
    idle(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
